// File: rtl/reg_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_share_pkg
// Description : Shared constants and helpers for the register-share arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_share_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;

  // Widest requester vector the one-hot helper can produce.
  localparam int MAX_REQ = 32;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One-hot encoding of an index, sized for the widest supported vector.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first active
//               request found scanning from ptr upward, wrapping around.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import reg_share_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   sel,
  output logic               any_req
);

  // Scan from the farthest offset down so the nearest request to ptr wins.
  always_comb begin
    int idx;
    sel     = '0;
    any_req = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) sel = IDX_W'(idx);
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_share_arbiter
// Description : Round-robin arbiter with bounded burst lock that is the sole
//               writer of one shared DATA_W-bit register.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter  int NUM_REQ  = NUM_REQ_DEF,
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int MAX_HOLD = 3,
  localparam int IDX_W    = idx_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         q,
  output logic [IDX_W-1:0]          owner,
  output logic                      valid
);

  // Hold counter must represent 0..MAX_HOLD.
  localparam int HC_W = $clog2(MAX_HOLD + 1);

  logic [DATA_W-1:0]  q_q,      q_d;
  logic [NUM_REQ-1:0] gnt_q,    gnt_d;
  logic [IDX_W-1:0]   owner_q,  owner_d;
  logic               valid_q,  valid_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HC_W-1:0]    hold_q,   hold_d;
  logic               locked_q, locked_d;

  logic [IDX_W-1:0]   rr_sel;
  logic               any_req;
  logic               lock_path;
  logic [IDX_W-1:0]   sel;
  logic [MAX_REQ-1:0] oh_full;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req     (req),
    .ptr     (rr_ptr_q),
    .sel     (rr_sel),
    .any_req (any_req)
  );

  assign oh_full = onehot(32'(sel));

  generate
    if (NUM_REQ < MAX_REQ) begin : g_oh_unused
      logic unused_oh_hi;
      assign unused_oh_hi = ^oh_full[MAX_REQ-1:NUM_REQ];
    end
  endgenerate

  // Choose the winner and compute next register, grant and lock state.
  always_comb begin
    q_d      = q_q;
    gnt_d    = '0;
    owner_d  = owner_q;
    valid_d  = valid_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = '0;
    locked_d = 1'b0;

    // A locked owner keeps the register while it still requests and has budget.
    lock_path = locked_q && req[owner_q] && (hold_q < HC_W'(MAX_HOLD));
    sel       = lock_path ? owner_q : rr_sel;

    if (any_req) begin
      q_d      = wdata[sel*DATA_W +: DATA_W];
      gnt_d    = oh_full[NUM_REQ-1:0];
      owner_d  = sel;
      valid_d  = 1'b1;
      hold_d   = (sel == owner_q && locked_q) ? hold_q + HC_W'(1) : HC_W'(1);
      locked_d = lock[sel] && (hold_d < HC_W'(MAX_HOLD));
      rr_ptr_d = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + IDX_W'(1);
    end
  end

  // State registers with synchronous reset overriding any request.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q      <= '0;
      gnt_q    <= '0;
      owner_q  <= '0;
      valid_q  <= 1'b0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
      locked_q <= locked_d;
    end
  end

  assign gnt   = gnt_q;
  assign q     = q_q;
  assign owner = owner_q;
  assign valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_share_arbiter
// Description : Directed and random self-checking bench for reg_share_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_share_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MH = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt;
  logic [DW-1:0]   q;
  logic [1:0]      owner;
  logic            valid;

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed as plain integers.
  int          m_ptr, m_owner, m_hold;
  bit          m_locked, m_valid;
  logic [DW-1:0] m_q;
  logic [N-1:0]  m_gnt;

  reg_share_arbiter #(
    .NUM_REQ  (N),
    .DATA_W   (DW),
    .MAX_HOLD (MH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .lock  (lock),
    .wdata (wdata),
    .gnt   (gnt),
    .q     (q),
    .owner (owner),
    .valid (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the reference model by one rising edge using the rules directly.
  task automatic model_edge(input bit r, input logic [N-1:0] rq,
                            input logic [N-1:0] lk, input logic [N*DW-1:0] wd);
    int s, nh;
    if (r) begin
      m_ptr = 0; m_owner = 0; m_hold = 0; m_locked = 0;
      m_valid = 0; m_q = '0; m_gnt = '0;
    end else if (rq == '0) begin
      m_gnt = '0; m_locked = 0; m_hold = 0;
    end else begin
      s = -1;
      if (m_locked && rq[m_owner] && m_hold < MH) s = m_owner;
      else begin
        for (int k = 0; k < N; k++) begin
          if (s < 0 && rq[(m_ptr + k) % N]) s = (m_ptr + k) % N;
        end
      end
      nh       = (s == m_owner && m_locked) ? m_hold + 1 : 1;
      m_locked = lk[s] && (nh < MH);
      m_hold   = nh;
      m_ptr    = (s + 1) % N;
      m_owner  = s;
      m_q      = wd[s*DW +: DW];
      m_gnt    = N'(1) << s;
      m_valid  = 1;
    end
  endtask

  // Drive one cycle of inputs, update the model, then compare all outputs.
  task automatic step(input bit r, input logic [N-1:0] rq,
                      input logic [N-1:0] lk, input logic [N*DW-1:0] wd);
    @(negedge clk);
    reset = r; req = rq; lock = lk; wdata = wd;
    @(posedge clk);
    model_edge(r, rq, lk, wd);
    #1;
    chk("q",     32'(q),     32'(m_q));
    chk("gnt",   32'(gnt),   32'(m_gnt));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("onehot0", 32'($onehot0(gnt)), 32'(1));
  endtask

  localparam logic [N*DW-1:0] LANES_ROT = {8'h13, 8'h12, 8'h11, 8'h10};

  initial begin
    logic [N*DW-1:0] wd;
    reset = 1'b1; req = '0; lock = '0; wdata = '0;
    m_ptr = 0; m_owner = 0; m_hold = 0; m_locked = 0;
    m_valid = 0; m_q = '0; m_gnt = '0;

    // Reset wins over a full request vector.
    step(1'b1, 4'b1111, 4'b0000, LANES_ROT);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);

    // Single requester on lane 2, then idle.
    step(1'b0, 4'b0100, 4'b0000, {8'h00, 8'hA5, 8'h00, 8'h00});
    chk("single_q", 32'(q), 32'hA5);
    chk("single_gnt", 32'(gnt), 32'b0100);
    chk("single_owner", 32'(owner), 32'd2);
    chk("single_valid", 32'(valid), 32'd1);
    step(1'b0, 4'b0000, 4'b0000, '0);
    chk("idle_gnt", 32'(gnt), 32'h0);
    chk("idle_q", 32'(q), 32'hA5);

    // Rotation with wrap, from a fresh pointer.
    step(1'b1, 4'b0000, 4'b0000, '0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1111, 4'b0000, LANES_ROT);
      chk("rot_gnt", 32'(gnt), 32'(1 << (i % 4)));
      chk("rot_q", 32'(q), 32'(8'h10 + (i % 4)));
    end

    // Lock capped at MAX_HOLD grants.
    step(1'b1, 4'b0000, 4'b0000, '0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b0011, 4'b0001, LANES_ROT);
      chk("cap_gnt", 32'(gnt), (i == 3) ? 32'b0010 : 32'b0001);
    end

    // Locked owner withdraws; rotation continues without an idle cycle.
    step(1'b1, 4'b0000, 4'b0000, '0);
    step(1'b0, 4'b1001, 4'b0001, LANES_ROT);
    step(1'b0, 4'b1001, 4'b0001, LANES_ROT);
    chk("rel_gnt2", 32'(gnt), 32'b0001);
    step(1'b0, 4'b1000, 4'b0001, LANES_ROT);
    chk("rel_gnt3", 32'(gnt), 32'b1000);
    chk("rel_q", 32'(q), 32'h13);

    // Reset in the middle of a locked burst.
    step(1'b1, 4'b0000, 4'b0000, '0);
    step(1'b0, 4'b0011, 4'b0001, LANES_ROT);
    step(1'b1, 4'b0011, 4'b0001, LANES_ROT);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_valid", 32'(valid), 32'h0);
    chk("mid_rst_q", 32'(q), 32'h0);
    step(1'b0, 4'b0011, 4'b0000, LANES_ROT);
    chk("post_rst_gnt", 32'(gnt), 32'b0001);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      wd = {$urandom, $urandom};
      step(($urandom_range(0, 49) == 0),
           N'($urandom_range(0, 3) == 0 ? 0 : $urandom),
           N'($urandom),
           wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Shares one DATA_W-bit storage register, built from the team's dff cells, between NUM_REQ requesters.
- Each cycle, a registered round-robin arbiter selects at most one requester and writes its data into the register.
- An optional lock lets the current owner hold the register for a bounded burst.
- Sits between the requester blocks and the shared register, and is the only writer of that register.

Parameters:
- NUM_REQ, 4: number of requesters; must be at least 2.
- DATA_W, 8: width of the shared register and of each write-data lane.
- MAX_HOLD, 3: maximum number of consecutive grants one requester may take through lock; must be at least 1.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising clk.
- req  input  NUM_REQ  per-requester write request; bit i belongs to requester i.
- lock  input  NUM_REQ  per-requester burst hold; only meaningful together with req.
- wdata  input  NUM_REQ*DATA_W  packed write data; lane i is wdata[i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  registered one-hot grant; bit i high means lane i was written at the preceding edge.
- q  output  DATA_W  current contents of the shared register.
- owner  output  IDX_W  index of the last requester that wrote; IDX_W = max(1, clog2(NUM_REQ)).
- valid  output  1  sticky; high once any write has occurred since reset.

Behaviour:
- Reset (reset=1 at a rising edge):
  - q=0, gnt=0, owner=0, valid=0.
  - Internal rr_ptr=0, hold_cnt=0, locked=0.
  - Reset overrides any request in the same cycle, including mid-burst.
- Selection (combinational, from registered state):
  - Locked path: if locked=1, req[owner]=1 and hold_cnt<MAX_HOLD, then sel=owner.
  - Round-robin path: otherwise, sel is the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - No request: if req=0, there is no selection.
- On a rising edge with a selection:
  - q<=lane sel; gnt<=one-hot(sel); owner<=sel; valid<=1.
- Lock and rotation update on a grant:
  - If sel==owner and locked=1: hold_cnt<=hold_cnt+1.
  - Otherwise: hold_cnt<=1.
  - locked<=lock[sel] and (new hold_cnt < MAX_HOLD).
  - rr_ptr<=(sel+1) mod NUM_REQ on every grant, so a released lock resumes rotation after the owner.
- On a rising edge with no request:
  - gnt<=0, locked<=0, hold_cnt<=0.
  - q, owner, valid and rr_ptr hold.
- Latency and handshake:
  - One cycle from req to the q update and to the gnt pulse.
  - A requester treats gnt[i]=1 as "my data is now in q".
  - A requester keeps req and wdata stable until it sees gnt, or drops req to withdraw.
- Boundary conditions:
  - Wrap-around: rr_ptr=NUM_REQ-1 with a grant there sets rr_ptr to 0.
  - Locked owner drops req: lock is released and round-robin resumes the same cycle.
  - MAX_HOLD=1: lock has no effect.
  - lock without req is ignored.
  - Simultaneous requests: exactly one grant per cycle; gnt is always one-hot or zero.
  - Fairness: starvation-free; a requester holding req waits at most (NUM_REQ-1)*MAX_HOLD grants.

Decomposition:
- Shared package reg_share_pkg holds:
  - The default constants NUM_REQ_DEF and DATA_W_DEF.
  - The IDX_W derivation.
  - A onehot(idx) function.
- One natural combinational sub-module, rr_pick:
  - Inputs: req vector and rr_ptr.
  - Outputs: sel index and any_req.
- The top level holds all registers, the lock/hold counter and the lane mux.

Test Plan:
1. Reset with all requests active: reset=1 with req=4'b1111 -> q=0, gnt=0, valid=0, owner=0 after the edge.
2. Single requester: req=4'b0100, lane2=8'hA5 for one cycle -> next cycle q=8'hA5, gnt=4'b0100, owner=2, valid=1; req=0 the following cycle -> gnt=0, q stays 8'hA5.
3. Rotation: req=4'b1111 held, lanes 8'h10/8'h11/8'h12/8'h13, no lock -> gnt sequence 0001, 0010, 0100, 1000, 0001 and q 8'h10, 8'h11, 8'h12, 8'h13, 8'h10 (wrap confirmed).
4. Lock cap: req=4'b0011, lock=4'b0001, MAX_HOLD=3 -> gnt 0001, 0001, 0001, then 0010, then 0001.
5. Lock released early: requester 0 locked with req=4'b1001, then req[0] drops after its second grant -> the next grant goes to requester 3 the following cycle; no idle cycle.
6. Reset mid-burst: reset=1 during the second locked grant -> all outputs return to reset values; after reset deasserts with req=4'b0011, the first grant is to 0001 (rr_ptr=0).
